usb_rx_decoder: RTL

// Receive half of the host serial link: deserialises 8N1 UART frames from the USB bridge
// rx line and latches each good byte as the new oscilloscope control value.

---
 rtl/usb_rx_decoder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/usb_rx_decoder.sv
// 8N1 UART receiver for the USB bridge rx line. Each good byte is latched onto the
// control bus; glitches and framing errors never reach control.
module usb_rx_decoder #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter logic [7:0]  CTRL_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] control
);

  localparam int unsigned DIV = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SW  = $clog2(OVERSAMPLE);

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] BIT_LAST  = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

  state_e        state_q, state_d;
  logic          rx_meta_q, rx_s_q;
  logic [DW-1:0] div_q, div_d;
  logic [SW-1:0] samp_q, samp_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic [7:0]    control_q, control_d;
  logic          tick;

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    state_d     = state_q;
    div_d       = tick ? '0 : div_q + 1'b1;
    samp_d      = samp_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    control_d   = control_q;
    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          // Restart the tick divider so sample points line up with the start edge.
          state_d = StStart;
          div_d   = '0;
          samp_d  = '0;
        end
      end
      StStart: begin
        if (tick) begin
          if (samp_q == HALF_LAST) begin
            samp_d  = '0;
            bit_d   = '0;
            state_d = rx_s_q ? StIdle : StData;
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (samp_q == BIT_LAST) begin
            samp_d  = '0;
            shift_d = {rx_s_q, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = StStop;
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (samp_q == BIT_LAST) begin
            samp_d    = '0;
            rx_data_d = shift_q;
            if (rx_s_q) begin
              rx_valid_d = 1'b1;
              control_d  = shift_q;
              state_d    = StIdle;
            end else begin
              frame_err_d = 1'b1;
              state_d     = StWaitHigh;
            end
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
      end
      StWaitHigh: begin
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      div_q       <= '0;
      samp_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      control_q   <= CTRL_RESET;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      div_q       <= div_d;
      samp_q      <= samp_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      control_q   <= control_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != StIdle);
  assign control   = control_q;

endmodule
